// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Purpose  : Memory-mapped interrupt controller. Synchronises up to NUM_SRC
//            peripheral interrupt lines, latches them as pending bits, masks
//            them with an enable register and drives one registered request
//            to the core. Software services requests with a claim/complete
//            handshake over the MW-stage data bus.
// Ports    : clk          - core clock
//            reset        - synchronous, active-low reset (0 = reset)
//            irq_src      - asynchronous peripheral interrupt lines
//            cpu_address  - byte address from the MW stage
//            cpu_data     - write data
//            write_enable - store strobe (already LSU-qualified)
//            read_enable  - load strobe (gates the claim side effect)
//            cout         - combinational read data, 0 outside the window
//            interrupt    - registered request to the core
// Register window (16 bytes at BASE_ADDR):
//            0 PENDING (W1C), 1 ENABLE (R/W), 2 CLAIM (read=claim,
//            write=complete), 3 RAW (read-only synchronised levels)
// Options  : `define IRQ_CTRL_LEVEL_EN for level-sensitive sources
//            (pending follows the synchronised level; no edge flop).
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [31:0]        cpu_address,
    input  logic [31:0]        cpu_data,
    input  logic               write_enable,
    input  logic               read_enable,
    output logic [31:0]        cout,
    output logic               interrupt
);

    localparam logic [1:0] c_off_pending = 2'd0;
    localparam logic [1:0] c_off_enable  = 2'd1;
    localparam logic [1:0] c_off_claim   = 2'd2;
    localparam logic [1:0] c_off_raw     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_interrupt;
    logic [4:0]         r_claimed_id;
    logic [NUM_SRC-1:0] r_s1;
    logic [NUM_SRC-1:0] r_s2;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_enable;

    logic               w_sel;
    logic [1:0]         w_offset;
    logic               w_wr;
    logic               w_rd;
    logic [NUM_SRC-1:0] w_active;
    logic [4:0]         w_id;
    logic [NUM_SRC-1:0] w_claim_onehot;
    logic               w_claim_rd;
    logic               w_complete;
    logic [NUM_SRC-1:0] w_pending_nxt;
    logic [NUM_SRC-1:0] w_enable_nxt;
    logic [NUM_SRC-1:0] w_active_nxt;
    logic               w_unused_ok;

    assign w_sel    = (cpu_address[31:4] == BASE_ADDR[31:4]);
    assign w_offset = cpu_address[3:2];
    assign w_wr     = write_enable & w_sel;
    // A write wins when both strobes are high, so the read side effect is dropped.
    assign w_rd     = read_enable & ~write_enable & w_sel;
    assign w_active = r_pending & r_enable;

    // Lowest index wins: scan downwards so the last hit is the lowest bit.
    always_comb begin
        w_id           = '0;
        w_claim_onehot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_id              = 5'(i + 1);
                w_claim_onehot    = '0;
                w_claim_onehot[i] = 1'b1;
            end
        end
    end

    assign w_claim_rd = w_rd & (w_offset == c_off_claim) & (w_id != 5'd0);
    assign w_complete = w_wr & (w_offset == c_off_claim) & (cpu_data[4:0] == r_claimed_id);

`ifdef IRQ_CTRL_LEVEL_EN
    assign w_pending_nxt = r_s2;
    assign w_unused_ok   = ^{cpu_address[1:0], cpu_data, w_claim_onehot};
`else
    logic [NUM_SRC-1:0] r_s3;
    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_w1c_mask;
    logic [NUM_SRC-1:0] w_claim_mask;

    assign w_edge       = r_s2 & ~r_s3;
    assign w_w1c_mask   = (w_wr && w_offset == c_off_pending) ? cpu_data[NUM_SRC-1:0] : '0;
    assign w_claim_mask = w_claim_rd ? w_claim_onehot : '0;
    // A new edge is ORed in last so it beats a same-cycle W1C or claim clear.
    assign w_pending_nxt = (r_pending & ~w_w1c_mask & ~w_claim_mask) | w_edge;
    assign w_unused_ok   = ^{cpu_address[1:0], cpu_data};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s3 <= '0;
        end else begin
            r_s3 <= r_s2;
        end
    end
`endif

    assign w_enable_nxt = (w_wr && w_offset == c_off_enable) ? cpu_data[NUM_SRC-1:0] : r_enable;
    assign w_active_nxt = w_pending_nxt & w_enable_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1         <= '0;
            r_s2         <= '0;
            r_pending    <= '0;
            r_enable     <= '0;
            r_claimed_id <= '0;
            r_interrupt  <= 1'b0;
            r_state      <= ST_IDLE;
        end else begin
            r_s1      <= irq_src;
            r_s2      <= r_s1;
            r_pending <= w_pending_nxt;
            r_enable  <= w_enable_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (|w_active) begin
                        r_state     <= ST_REQ;
                        r_interrupt <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (w_claim_rd) begin
                        r_state      <= ST_SERVICE;
                        r_claimed_id <= w_id;
                        r_interrupt  <= 1'b0;
                    end else if (!(|w_active_nxt)) begin
                        // Request withdrawn by a W1C or an ENABLE write.
                        r_state     <= ST_IDLE;
                        r_interrupt <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (w_complete) begin
                        r_state      <= ST_IDLE;
                        r_claimed_id <= '0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_interrupt <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cout = '0;
        if (w_sel) begin
            case (w_offset)
                c_off_pending: cout[NUM_SRC-1:0] = r_pending;
                c_off_enable:  cout[NUM_SRC-1:0] = r_enable;
                c_off_claim:   cout[4:0]         = w_id;
                c_off_raw:     cout[NUM_SRC-1:0] = r_s2;
                default:       cout              = '0;
            endcase
        end
    end

    assign interrupt = r_interrupt;

endmodule
`default_nettype wire
